// File: rtl/cfg_reg_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters read/write access to a register bank.
// The bank contents are exported as bank_data for datapath configuration.
module cfg_reg_arbiter #(
    parameter int                    NUM_REQ     = 4,
    parameter int                    ADDR_WIDTH  = 3,
    parameter int                    WORD_WIDTH  = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                 clock,
    input  logic                                 areset_n,
    input  logic                                 clear,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]        req_wdata,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [WORD_WIDTH-1:0]                rsp_rdata,
    output logic [(2**ADDR_WIDTH)*WORD_WIDTH-1:0] bank_data
);

    localparam int                 DEPTH       = 2**ADDR_WIDTH;
    localparam int                 PTR_W       = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]     NUM_REQ_EXT = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]   LAST_IDX    = PTR_W'(NUM_REQ - 1);

    logic [WORD_WIDTH-1:0] bank_q [DEPTH];
    logic [WORD_WIDTH-1:0] bank_d [DEPTH];
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [WORD_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_any;
    logic [PTR_W:0]        cand;
    logic [ADDR_WIDTH-1:0] sel_addr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_pack
        assign bank_data[i*WORD_WIDTH +: WORD_WIDTH] = bank_q[i];
    end

    // Search upward from ptr, wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= NUM_REQ_EXT) begin
                cand = cand - NUM_REQ_EXT;
            end
            if (!gnt_any && !clear && req_valid[cand[PTR_W-1:0]]) begin
                gnt_any                  = 1'b1;
                gnt_idx                  = cand[PTR_W-1:0];
                grant[cand[PTR_W-1:0]]   = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign sel_addr  = addr_arr[gnt_idx];

    // Only one access per cycle, so a read always sees the bank as of the start of its cycle.
    always_comb begin
        bank_d      = bank_q;
        ptr_d       = ptr_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_d[i] = RESET_VALUE;
            end
            ptr_d = '0;
        end else if (gnt_any) begin
            ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            if (req_write[gnt_idx]) begin
                bank_d[sel_addr] = wdata_arr[gnt_idx];
            end else begin
                rsp_valid_d = grant;
                rsp_rdata_d = bank_q[sel_addr];
            end
        end
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= RESET_VALUE;
            end
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            bank_q      <= bank_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // A clear arriving in the response cycle drops the response of the previous read.
    assign rsp_valid = rsp_valid_q & ~{NUM_REQ{clear}};
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/cfg_reg_arbiter.md
CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, word address width; bank depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WORD_WIDTH, default 32, data width.
REQ-004 SHALL have parameter RESET_VALUE, default 0, value of every bank word after reset or clear.
REQ-005 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port areset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port clear  input  1  synchronous clear of the bank and the arbiter.
REQ-008 SHALL have port req_valid  input  NUM_REQ  per-requester access request.
REQ-009 SHALL have port req_write  input  NUM_REQ  per-requester access type: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address; requester i uses slice i.
REQ-011 SHALL have port req_wdata  input  NUM_REQ*WORD_WIDTH  per-requester write data; requester i uses slice i.
REQ-012 SHALL have port req_ready  output  NUM_REQ  one-hot grant; the access completes when valid and ready are both high.
REQ-013 SHALL have port rsp_valid  output  NUM_REQ  one-hot read-response strobe.
REQ-014 SHALL have port rsp_rdata  output  WORD_WIDTH  read data, meaningful only while a rsp_valid bit is high.
REQ-015 SHALL have port bank_data  output  (2**ADDR_WIDTH)*WORD_WIDTH  registered bank contents for datapath configuration.

Function
REQ-016 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid, the priority pointer and clear.
REQ-017 SHALL arbitrate round-robin: the search starts at pointer ptr and moves upward modulo NUM_REQ; the first requester with valid high is granted.
REQ-018 SHALL set ptr to (g+1) mod NUM_REQ after granting requester g; with no grant, ptr holds.
REQ-019 SHALL update bank word req_addr[g] with req_wdata[g] at the end of a write grant cycle.
REQ-020 SHALL, for a read grant in cycle N, assert rsp_valid[g] in cycle N+1 only, with rsp_rdata equal to the bank word at that address during cycle N.
REQ-021 SHALL return the newly written value to a read granted in the cycle after a write to the same address.
REQ-022 SHALL hold rsp_rdata at its last value when no rsp_valid bit is high.
REQ-023 SHALL, while clear is high, grant nothing (req_ready = 0) and, at the clock edge, load every bank word with RESET_VALUE, set ptr to 0 and rsp_valid to 0.
REQ-024 SHALL let clear drop a read granted in the previous cycle: that read's rsp_valid is suppressed.
REQ-025 SHALL ignore a requester's req_write, req_addr and req_wdata when it is not granted; a requester keeps its request until it sees req_ready.
REQ-026 SHALL drive bank_data directly from the bank registers, with no combinational path from the inputs.

Reset
REQ-027 SHALL, on areset_n low, immediately set every bank word to RESET_VALUE, ptr to 0, rsp_valid to 0 and rsp_rdata to 0, independent of clock.
REQ-028 SHALL hold this state while areset_n is low; arbitration resumes on the first rising clock edge after areset_n goes high.
REQ-029 SHALL have an abandoned access when reset is asserted mid-access: a pending read gives no response and a same-cycle write is lost.

Verification
REQ-030 SHALL cover the round-robin case: all 4 requesters issue reads continuously from ptr=0 -> grants 0,1,2,3,0,1 on consecutive cycles, with one rsp_valid per cycle lagging one cycle.
REQ-031 SHALL cover write then read: requester 2 writes 0xDEADBEEF to address 5, then requester 0 reads address 5 the next cycle -> rsp_valid[0]=1 and rsp_rdata=0xDEADBEEF one cycle later, and bank_data word 5 = 0xDEADBEEF.
REQ-032 SHALL cover a single requester: only requester 3 is valid, with ptr=1 -> granted immediately, and ptr becomes 0.
REQ-033 SHALL cover clear: clear is pulsed while requesters 0 and 1 are valid and the previous cycle granted a read -> no grant, no rsp_valid, all bank words = RESET_VALUE, and requester 0 is granted first after clear.
REQ-034 SHALL cover reset mid-operation: areset_n drops between clock edges after 3 writes -> bank_data = all RESET_VALUE, rsp_valid = 0 with no edge needed, and after release the next grant starts at requester 0.
